// File: rtl/pram_arbiter_if.sv
// pram_arbiter_if: boot/data/fetch requester signals and the PRAM port shared through pram_arbiter
interface pram_arbiter_if #(
    parameter int ADDR_W = 12
) ();
    logic              boot_req;
    logic [ADDR_W-1:0] boot_addr;
    logic [31:0]       boot_wdata;
    logic              boot_last;
    logic              boot_gnt;
    logic              done_pram_load;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_gnt;
    logic              data_rvalid;
    logic [31:0]       data_rdata;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [31:0]       fetch_rdata;
    logic              pram_en;
    logic [3:0]        pram_we;
    logic [ADDR_W-1:0] pram_addr;
    logic [31:0]       pram_wdata;
    logic [31:0]       pram_rdata;
    modport slave (
        input  boot_req, boot_addr, boot_wdata, boot_last,
        input  data_req, data_we, data_addr, data_wdata, data_wstrb,
        input  fetch_req, fetch_addr, pram_rdata,
        output boot_gnt, done_pram_load, data_gnt, data_rvalid, data_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output pram_en, pram_we, pram_addr, pram_wdata
    );
    modport master (
        output boot_req, boot_addr, boot_wdata, boot_last,
        output data_req, data_we, data_addr, data_wdata, data_wstrb,
        output fetch_req, fetch_addr, pram_rdata,
        input  boot_gnt, done_pram_load, data_gnt, data_rvalid, data_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  pram_en, pram_we, pram_addr, pram_wdata
    );
endinterface

// File: rtl/pram_arbiter.sv
// pram_arbiter: PRAM sharing between boot writes, data port and fetch; PRAM_ARB_STATS_EN adds stall counters
module pram_arbiter #(
    parameter int ADDR_W          = 12,
    parameter int RD_LAT          = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PRAM_ARB_STATS_EN
    output logic [15:0] fetch_stall_cnt,
    output logic [15:0] data_stall_cnt,
`endif
    pram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {BOOT, IDLE, RD_WAIT} state_t;
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            state;
    logic              done;
    logic [SW-1:0]     streak;
    logic [CW-1:0]     cnt;
    logic              owner_fetch;
    logic [31:0]       data_q;
    logic [31:0]       fetch_q;
    logic              starve;
    logic              boot_win;
    logic              data_win;
    logic              fetch_win;
    logic              rd_done;
    logic [ADDR_W-1:0] sel_addr;

    // Grants are combinational so each one coincides with its PRAM access; reset masks them
    assign starve    = streak == SW'(MAX_DATA_STREAK) && bus.fetch_req;
    assign boot_win  = !reset && state == BOOT && bus.boot_req;
    assign data_win  = !reset && state == IDLE && bus.data_req && !starve;
    assign fetch_win = !reset && state == IDLE && bus.fetch_req && !data_win;
    assign rd_done   = !reset && state == RD_WAIT && cnt == '0;
    assign sel_addr  = boot_win ? bus.boot_addr : data_win ? bus.data_addr : fetch_win ? bus.fetch_addr : '0;

    assign bus.boot_gnt       = boot_win;
    assign bus.data_gnt       = data_win;
    assign bus.fetch_gnt      = fetch_win;
    assign bus.done_pram_load = done;
    assign bus.pram_en        = boot_win || data_win || fetch_win;
    assign bus.pram_we        = boot_win ? 4'hF : (data_win && bus.data_we) ? bus.data_wstrb : 4'h0;
    assign bus.pram_addr      = sel_addr;
    assign bus.pram_wdata     = boot_win ? bus.boot_wdata : (data_win && bus.data_we) ? bus.data_wdata : '0;
    // Read data passes straight through on its valid cycle and is held afterwards
    assign bus.data_rvalid    = rd_done && !owner_fetch;
    assign bus.fetch_rvalid   = rd_done && owner_fetch;
    assign bus.data_rdata     = bus.data_rvalid ? bus.pram_rdata : data_q;
    assign bus.fetch_rdata    = bus.fetch_rvalid ? bus.pram_rdata : fetch_q;

    // Phase/read sequencing: boot until the last word, then one outstanding read at a time
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            done        <= 1'b0;
            cnt         <= '0;
            owner_fetch <= 1'b0;
            data_q      <= '0;
            fetch_q     <= '0;
        end else begin
            case (state)
                BOOT: if (bus.boot_req && bus.boot_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                IDLE: if ((data_win && !bus.data_we) || fetch_win) begin
                    state       <= RD_WAIT;
                    owner_fetch <= fetch_win;
                    cnt         <= CW'(RD_LAT - 1);
                end
                RD_WAIT: if (cnt == '0) state <= IDLE;
                    else cnt <= cnt - CW'(1);
                default: state <= BOOT;
            endcase
            if (bus.data_rvalid) data_q <= bus.pram_rdata;
            if (bus.fetch_rvalid) fetch_q <= bus.pram_rdata;
        end
    end

    // Count consecutive data wins over a waiting fetch; any fetch win or idle fetch clears it
    always_ff @(posedge clk) begin
        if (reset || !bus.fetch_req || fetch_win) streak <= '0;
        else if (data_win) streak <= streak + SW'(1);
    end

`ifdef PRAM_ARB_STATS_EN
    // Saturating post-boot stall counters per requester
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_stall_cnt <= '0;
            data_stall_cnt  <= '0;
        end else if (done) begin
            if (bus.fetch_req && !fetch_win && fetch_stall_cnt != 16'hFFFF) fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
            if (bus.data_req && !data_win && data_stall_cnt != 16'hFFFF) data_stall_cnt <= data_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pram_arbiter.sv
// tb_pram_arbiter: directed stimulus against a cycle-level reference model of pram_arbiter
`timescale 1ns/1ps
module tb_pram_arbiter;
    localparam int AW   = 12;
    localparam int LAT  = 1;
    localparam int MAXS = 4;

    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    pram_arbiter_if #(.ADDR_W(AW)) b1 ();
    pram_arbiter_if #(.ADDR_W(AW)) b2 ();
`ifdef PRAM_ARB_STATS_EN
    logic [15:0] fs1, ds1, fs2, ds2;
`endif

    pram_arbiter #(.ADDR_W(AW), .RD_LAT(LAT), .MAX_DATA_STREAK(MAXS)) u_dut (
        .clk(clk),
        .reset(rst1),
`ifdef PRAM_ARB_STATS_EN
        .fetch_stall_cnt(fs1),
        .data_stall_cnt(ds1),
`endif
        .bus(b1)
    );

    pram_arbiter #(.ADDR_W(AW), .RD_LAT(2), .MAX_DATA_STREAK(MAXS)) u_dut2 (
        .clk(clk),
        .reset(rst2),
`ifdef PRAM_ARB_STATS_EN
        .fetch_stall_cnt(fs2),
        .data_stall_cnt(ds2),
`endif
        .bus(b2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PRAM macros: byte-writable, read data RD_LAT cycles after the enable
    logic [31:0] mem1 [4096];
    logic [31:0] mem2 [4096];
    logic [31:0] rd1  = '0;
    logic [31:0] rd2a = '0;
    logic [31:0] rd2b = '0;
    assign b1.pram_rdata = rd1;
    assign b2.pram_rdata = rd2b;

    always @(posedge clk) begin
        if (b1.pram_en && b1.pram_we == 4'h0) rd1 <= mem1[b1.pram_addr];
        for (int i = 0; i < 4; i++)
            if (b1.pram_en && b1.pram_we[i]) mem1[b1.pram_addr][i*8 +: 8] <= b1.pram_wdata[i*8 +: 8];
    end

    always @(posedge clk) begin
        if (b2.pram_en && b2.pram_we == 4'h0) rd2a <= mem2[b2.pram_addr];
        rd2b <= rd2a;
        for (int i = 0; i < 4; i++)
            if (b2.pram_en && b2.pram_we[i]) mem2[b2.pram_addr][i*8 +: 8] <= b2.pram_wdata[i*8 +: 8];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: schedule-based view of the arbiter (read window = grant .. grant+LAT)
    bit          m_done   = 1'b0;
    bit          m_rv_f   = 1'b0;
    int          m_rv_cyc = -1;
    int          m_free   = 0;
    int          m_streak = 0;
    logic [31:0] m_rv_data = '0;
    logic [31:0] m_dlast   = '0;
    logic [31:0] m_flast   = '0;
    logic [31:0] sh [4096];

    initial forever begin : model
        logic [31:0] e_drd, e_frd, e_wd;
        logic [3:0]  e_we;
        logic [AW-1:0] e_addr;
        bit e_bg, e_dg, e_fg, e_drv, e_frv, e_en;
        @(negedge clk);
        #3;
        e_bg = 0; e_dg = 0; e_fg = 0; e_drv = 0; e_frv = 0;
        e_drd = m_dlast; e_frd = m_flast; e_we = 4'h0; e_addr = '0; e_wd = '0;
        if (!rst1) begin
            if (!m_done) begin
                if (b1.boot_req) begin
                    e_bg = 1; e_we = 4'hF; e_addr = b1.boot_addr; e_wd = b1.boot_wdata;
                end
            end else begin
                if (cyc == m_rv_cyc) begin
                    if (m_rv_f) begin e_frv = 1; e_frd = m_rv_data; end
                    else begin e_drv = 1; e_drd = m_rv_data; end
                end
                if (cyc >= m_free) begin
                    e_dg = b1.data_req && !(m_streak == MAXS && b1.fetch_req);
                    e_fg = b1.fetch_req && !e_dg;
                    if (e_dg) begin
                        e_addr = b1.data_addr;
                        if (b1.data_we) begin e_we = b1.data_wstrb; e_wd = b1.data_wdata; end
                    end
                    if (e_fg) e_addr = b1.fetch_addr;
                end
            end
        end
        e_en = e_bg || e_dg || e_fg;
        chk("m_boot_gnt", 32'(b1.boot_gnt), 32'(e_bg));
        chk("m_data_gnt", 32'(b1.data_gnt), 32'(e_dg));
        chk("m_fetch_gnt", 32'(b1.fetch_gnt), 32'(e_fg));
        chk("m_pram_en", 32'(b1.pram_en), 32'(e_en));
        chk("m_pram_we", 32'(b1.pram_we), 32'(e_we));
        if (e_en) chk("m_pram_addr", 32'(b1.pram_addr), 32'(e_addr));
        if (e_we != 4'h0) chk("m_pram_wdata", b1.pram_wdata, e_wd);
        chk("m_data_rvalid", 32'(b1.data_rvalid), 32'(e_drv));
        chk("m_fetch_rvalid", 32'(b1.fetch_rvalid), 32'(e_frv));
        chk("m_data_rdata", b1.data_rdata, e_drd);
        chk("m_fetch_rdata", b1.fetch_rdata, e_frd);
        chk("m_done", 32'(b1.done_pram_load), 32'(m_done));
        if (rst1) begin
            m_done = 0; m_rv_cyc = -1; m_free = 0; m_streak = 0; m_dlast = '0; m_flast = '0;
        end else begin
            if (e_bg) begin
                sh[e_addr] = e_wd;
                if (b1.boot_last) m_done = 1;
            end
            if (e_drv) m_dlast = e_drd;
            if (e_frv) m_flast = e_frd;
            for (int i = 0; i < 4; i++)
                if (e_dg && e_we[i]) sh[e_addr][i*8 +: 8] = e_wd[i*8 +: 8];
            if ((e_dg && !b1.data_we) || e_fg) begin
                m_rv_cyc = cyc + LAT; m_free = cyc + LAT + 1; m_rv_f = e_fg; m_rv_data = sh[e_addr];
            end
            if (!b1.fetch_req || e_fg) m_streak = 0;
            else if (e_dg) m_streak++;
        end
    end

    task automatic boot_wr(input logic [AW-1:0] a, input logic [31:0] d, input bit last);
        @(negedge clk);
        b1.boot_req = 1'b1; b1.boot_addr = a; b1.boot_wdata = d; b1.boot_last = last;
        #3;
        chk("boot_gnt", 32'(b1.boot_gnt), 1);
        chk("boot_we", 32'(b1.pram_we), 32'hF);
        chk("boot_fetch_gnt", 32'(b1.fetch_gnt), 0);
    endtask

    task automatic data_op(input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit hold, output int gc);
        int n = 0;
        @(negedge clk);
        b1.data_req = 1'b1; b1.data_we = we; b1.data_addr = a; b1.data_wdata = d; b1.data_wstrb = s;
        #3;
        while (!b1.data_gnt && n < 40) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("data_gnt_wait", 32'(n < 40), 1);
        gc = cyc;
        if (!hold) begin
            @(negedge clk);
            b1.data_req = 1'b0;
        end
    endtask

    task automatic fetch_op(input logic [AW-1:0] a, input bit hold, output int gc);
        int n = 0;
        @(negedge clk);
        b1.fetch_req = 1'b1; b1.fetch_addr = a;
        #3;
        while (!b1.fetch_gnt && n < 40) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("fetch_gnt_wait", 32'(n < 40), 1);
        gc = cyc;
        if (!hold) begin
            @(negedge clk);
            b1.fetch_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected end of test");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        int t, gd, gf;
        int g[6];
        {b1.boot_req, b1.boot_last, b1.data_req, b1.data_we, b1.fetch_req} = '0;
        b1.boot_addr = '0; b1.boot_wdata = '0; b1.data_addr = '0; b1.data_wdata = '0;
        b1.data_wstrb = '0; b1.fetch_addr = '0;
        {b2.boot_req, b2.boot_last, b2.data_req, b2.data_we, b2.fetch_req} = '0;
        b2.boot_addr = '0; b2.boot_wdata = '0; b2.data_addr = '0; b2.data_wdata = '0;
        b2.data_wstrb = '0; b2.fetch_addr = '0;
        b1.boot_req = 1'b1; b1.boot_addr = 12'h3FF;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_done", 32'(b1.done_pram_load), 0);
        chk("rst_boot_gnt", 32'(b1.boot_gnt), 0);
        chk("rst_pram_en", 32'(b1.pram_en), 0);
        chk("rst_fetch_rdata", b1.fetch_rdata, 0);
        @(negedge clk);
        b1.boot_req = 1'b0; rst1 = 1'b0;
        b1.fetch_req = 1'b1; b1.fetch_addr = 12'h000;
        boot_wr(12'h000, 32'h00000013, 0);
        boot_wr(12'h001, 32'h00100093, 0);
        boot_wr(12'h002, 32'h00208113, 1);
        @(negedge clk);
        b1.boot_req = 1'b0; b1.boot_last = 1'b0; b1.fetch_req = 1'b0;
        #3;
        chk("boot_done", 32'(b1.done_pram_load), 1);
        @(negedge clk);
        b1.boot_req = 1'b1; b1.boot_addr = 12'h002; b1.boot_wdata = 32'hBAD0BAD0;
        #3;
        chk("late_boot_gnt", 32'(b1.boot_gnt), 0);
        chk("late_boot_en", 32'(b1.pram_en), 0);
        @(negedge clk);
        b1.boot_req = 1'b0;
        fetch_op(12'h002, 1, t);
        @(negedge clk);
        b1.fetch_addr = 12'h001;
        #3;
        chk("f_rvalid_T1", 32'(b1.fetch_rvalid), 1);
        chk("f_rdata_T1", b1.fetch_rdata, 32'h00208113);
        chk("f_gnt_T1", 32'(b1.fetch_gnt), 0);
        @(negedge clk);
        #3;
        chk("f_gnt_T2", 32'(b1.fetch_gnt), 1);
        chk("f_gnt_cycle", 32'(cyc - t), 2);
        @(negedge clk);
        b1.fetch_req = 1'b0;
        #3;
        chk("f_rdata_2", b1.fetch_rdata, 32'h00100093);
        data_op(1, 12'h100, 32'hCAFEF00D, 4'hF, 0, t);
        fork
            data_op(0, 12'h100, 32'h0, 4'h0, 0, gd);
            fetch_op(12'h001, 0, gf);
        join
        #3;
        chk("cont_order", 32'(gf - gd), 2);
        chk("cont_drdata", b1.data_rdata, 32'hCAFEF00D);
        chk("cont_frdata", b1.fetch_rdata, 32'h00100093);
        fork
            fetch_op(12'h000, 0, gf);
            for (int i = 0; i < 6; i++) data_op(1, AW'(32'h20 + i), 32'h1000 + i, 4'hF, i < 5, g[i]);
        join
        chk("starve_4", 32'(g[3] - g[0]), 3);
        chk("starve_f", 32'(gf - g[3]), 1);
        chk("starve_resume", 32'(g[4] - gf), 2);
        chk("starve_next", 32'(g[5] - g[4]), 1);
        data_op(1, 12'h010, 32'h11223344, 4'hF, 1, t);
        data_op(1, 12'h010, 32'h00AB0000, 4'b0100, 1, t);
        @(negedge clk);
        b1.data_req = 1'b0;
        #3;
        chk("store_no_rvalid", 32'(b1.data_rvalid), 0);
        data_op(1, 12'h010, 32'hFFFFFFFF, 4'h0, 0, t);
        data_op(0, 12'h010, 32'h0, 4'h0, 1, t);
        @(negedge clk);
        b1.data_req = 1'b0;
        #3;
        chk("bs_rvalid", 32'(b1.data_rvalid), 1);
        chk("bs_rdata", b1.data_rdata, 32'h11AB3344);
        fork
            data_op(1, 12'h030, 32'hDEADBEEF, 4'hF, 0, gd);
            fetch_op(12'h030, 1, gf);
        join
        @(negedge clk);
        b1.fetch_req = 1'b0;
        #3;
        chk("raw_order", 32'(gf - gd), 1);
        chk("raw_rvalid", 32'(b1.fetch_rvalid), 1);
        chk("raw_rdata", b1.fetch_rdata, 32'hDEADBEEF);
        @(negedge clk);
        rst2 = 1'b0;
        b2.boot_req = 1'b1; b2.boot_addr = 12'h005; b2.boot_wdata = 32'h12345678; b2.boot_last = 1'b1;
        #3;
        chk("d2_boot_gnt", 32'(b2.boot_gnt), 1);
        @(negedge clk);
        b2.boot_req = 1'b0; b2.boot_last = 1'b0; b2.fetch_req = 1'b1; b2.fetch_addr = 12'h005;
        #3;
        chk("d2_done", 32'(b2.done_pram_load), 1);
        chk("d2_f_gnt", 32'(b2.fetch_gnt), 1);
        @(negedge clk);
        b2.fetch_req = 1'b0;
        #3;
        chk("d2_rv_T1", 32'(b2.fetch_rvalid), 0);
        @(negedge clk);
        #3;
        chk("d2_rv_T2", 32'(b2.fetch_rvalid), 1);
        chk("d2_rd_T2", b2.fetch_rdata, 32'h12345678);
        @(negedge clk);
        b2.fetch_req = 1'b1;
        #3;
        chk("d2_f_gnt2", 32'(b2.fetch_gnt), 1);
        @(negedge clk);
        b2.fetch_req = 1'b0; rst2 = 1'b1;
        #3;
        chk("d2_rst_rv", 32'(b2.fetch_rvalid), 0);
        @(negedge clk);
        rst2 = 1'b0; b2.boot_req = 1'b1; b2.fetch_req = 1'b1;
        #3;
        chk("d2_post_rv", 32'(b2.fetch_rvalid), 0);
        chk("d2_post_done", 32'(b2.done_pram_load), 0);
        chk("d2_post_boot", 32'(b2.boot_gnt), 1);
        chk("d2_post_fgnt", 32'(b2.fetch_gnt), 0);
        chk("d2_post_frd", b2.fetch_rdata, 0);
        @(negedge clk);
        b2.boot_req = 1'b0; b2.fetch_req = 1'b0;
        #3;
        chk("d2_post_rv2", 32'(b2.fetch_rvalid), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
